// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-granular arbiter sharing one UART byte transmitter
// between N_REQ packet sources. A grant is held from the first byte to the last byte's done.
// Optional per-byte watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               uart_start_tx,
    output logic [7:0]         uart_tx_din,
    input  logic               uart_tx_done,
    output logic               abort_flag
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CND_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic               start_q, start_d;
    logic               abort_q, abort_d;
    logic [7:0]         din_q, din_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0]        cnt_q, cnt_d;
`endif

    logic               pick_vld_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [CND_W-1:0]   cand_c;

    // First pending request searching upward from rr_ptr+1 with wrap-around.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        cand_c     = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand_c = CND_W'(rr_ptr_q) + CND_W'(k);
            if (cand_c >= CND_W'(N_REQ)) begin
                cand_c = cand_c - CND_W'(N_REQ);
            end
            if (!pick_vld_c && req[cand_c[IDX_W-1:0]]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = cand_c[IDX_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic; every register holds unless changed below.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        last_d   = last_q;
        start_d  = 1'b0;
        din_d    = din_q;
        ack_d    = '0;
        abort_d  = abort_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_vld_c) begin
                    grant_d = N_REQ'(1) << pick_idx_c;
                    g_d     = pick_idx_c;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (req[g_q]) begin
                    start_d = 1'b1;
                    din_d   = req_byte[{g_q, 3'b000} +: 8];
                    last_d  = req_last[g_q];
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = ST_WAIT;
                end else begin
                    // requester withdrew mid-packet: abandon it
                    abort_d  = 1'b1;
                    rr_ptr_d = g_q;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (uart_tx_done) begin
                    ack_d[g_q] = 1'b1;
                    if (last_q) begin
                        rr_ptr_d = g_q;
                        grant_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_SEND;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    abort_d  = 1'b1;
                    rr_ptr_d = g_q;
                    grant_d  = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            g_q      <= '0;
            rr_ptr_q <= LAST_IDX;
            last_q   <= 1'b0;
            start_q  <= 1'b0;
            din_q    <= 8'h00;
            abort_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
            last_q   <= last_d;
            start_q  <= start_d;
            din_q    <= din_d;
            abort_q  <= abort_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign grant         = grant_q;
    assign req_ack       = ack_q;
    assign uart_start_tx = start_q;
    assign uart_tx_din   = din_q;
    assign abort_flag    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of arbitration outcomes, directed multi-cycle
// sequences, and randomized packet traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 3;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, req_last, req_ack, grant;
    logic [8*N-1:0] req_byte;
    logic           uart_start_tx, uart_tx_done, abort_flag;
    logic [7:0]     uart_tx_din;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_byte(req_byte), .req_last(req_last),
        .req_ack(req_ack), .grant(grant), .uart_start_tx(uart_start_tx),
        .uart_tx_din(uart_tx_din), .uart_tx_done(uart_tx_done), .abort_flag(abort_flag));

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        logic [7:0]   exp_din;
    } vec_t;
    vec_t vt [12];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // packet sources
    logic [7:0] pkt_mem [N][8];
    int pkt_len [N];
    int pkt_pos [N];
    bit active  [N];

    // UART model
    int done_timer = 0;
    bit uart_hang  = 0;
    int dly_min    = 10;
    int dly_max    = 10;

    // transaction-level reference
    bit chk_en   = 0;
    bit rnd_mode = 0;
    int m_last   = N - 1;
    int m_owner  = -1;
    logic [N-1:0] req_prev   = '0;
    logic [N-1:0] grant_prev = '0;
    int n_start = 0, n_ack = 0, pkts_begun = 0, pkts_done = 0;
    int last_start_cyc = 0;
    logic [7:0] last_din = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v = '0;
        if (i >= 0 && i < N) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (active[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req[i]            = active[i];
            req_byte[i*8 +: 8] = pkt_mem[i][pkt_pos[i]];
            req_last[i]       = (pkt_pos[i] == pkt_len[i] - 1);
        end
        req_prev = req;
    endtask

    task automatic new_pkt(input int i, input int len, input logic [7:0] base);
        for (int j = 0; j < len; j++) pkt_mem[i][j] = base + 8'(j * 7);
        pkt_len[i] = len;
        pkt_pos[i] = 0;
        active[i]  = 1'b1;
        pkts_begun++;
    endtask

    // Packet-level expectations: RR pick from idle, grant held, release on last ack, bytes in order.
    task automatic model_check();
        if (grant_prev == '0) begin
            int w = rr_pick(req_prev, m_last);
            chk("arb_pick", 32'(grant), 32'(onehot(w)));
            if (w >= 0) m_owner = w;
            if (req_ack != '0) chk("ack_while_idle", 32'(req_ack), 0);
        end else if (grant != '0) begin
            chk("grant_hold", 32'(grant), 32'(grant_prev));
            if (req_ack != '0) chk("ack_owner", 32'(req_ack), 32'(onehot(m_owner)));
        end else begin
            chk("release_owner_valid", 32'(m_owner >= 0), 1);
            if (m_owner >= 0) begin
                chk("release_on_ack", 32'(req_ack), 32'(onehot(m_owner)));
                chk("release_on_last", 32'(pkt_pos[m_owner]), 32'(pkt_len[m_owner] - 1));
                m_last = m_owner;
            end
            m_owner = -1;
        end
        if (uart_start_tx) begin
            chk("start_owner_valid", 32'(m_owner >= 0), 1);
            if (m_owner >= 0) chk("start_din", 32'(uart_tx_din), 32'(pkt_mem[m_owner][pkt_pos[m_owner]]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (chk_en) model_check();
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                n_ack++;
                if (active[i]) begin
                    pkt_pos[i]++;
                    if (pkt_pos[i] >= pkt_len[i]) begin
                        active[i]  = 1'b0;
                        pkt_pos[i] = 0;
                        pkts_done++;
                    end
                end
            end
        end
        uart_tx_done = 1'b0;
        if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) uart_tx_done = 1'b1;
        end
        if (uart_start_tx) begin
            n_start++;
            last_start_cyc = cyc;
            last_din       = uart_tx_din;
            if (!uart_hang) done_timer = int'($urandom_range(dly_max, dly_min));
        end
        if (rnd_mode) begin
            for (int i = 0; i < N; i++)
                if (!active[i] && $urandom_range(7, 0) == 0)
                    new_pkt(i, int'($urandom_range(4, 1)), 8'($urandom));
        end
        apply();
        grant_prev = grant;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (any_active() && k < bound) begin
            step();
            k++;
        end
        chk("wait_idle_bound", 32'(any_active()), 0);
    endtask

    // One single-byte packet per set bit; losers withdraw once the grant is seen.
    task automatic run_single(input logic [N-1:0] pat, output logic [N-1:0] g, output int waited);
        for (int i = 0; i < N; i++) if (pat[i]) new_pkt(i, 1, 8'hA0 + 8'(i));
        apply();
        waited = 0;
        while (grant == '0 && waited < 5) begin
            step();
            waited++;
        end
        g = grant;
        for (int i = 0; i < N; i++) if (!g[i]) active[i] = 1'b0;
        apply();
        wait_idle(200);
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            active[i]  = 1'b0;
            pkt_pos[i] = 0;
            pkt_len[i] = 1;
        end
        done_timer   = 0;
        uart_tx_done = 1'b0;
        uart_hang    = 1'b0;
        m_last       = N - 1;
        m_owner      = -1;
        grant_prev   = '0;
        apply();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] g;
        int w, t_grant, t_s1, t_s2, t_a1, s0, a0, bad;
        logic [7:0] d1, d2;

        vt[0]  = '{3'b001, 3'b001, 8'hA0};
        vt[1]  = '{3'b111, 3'b010, 8'hA1};
        vt[2]  = '{3'b111, 3'b100, 8'hA2};
        vt[3]  = '{3'b111, 3'b001, 8'hA0};
        vt[4]  = '{3'b101, 3'b100, 8'hA2};
        vt[5]  = '{3'b011, 3'b001, 8'hA0};
        vt[6]  = '{3'b001, 3'b001, 8'hA0};
        vt[7]  = '{3'b110, 3'b010, 8'hA1};
        vt[8]  = '{3'b001, 3'b001, 8'hA0};
        vt[9]  = '{3'b100, 3'b100, 8'hA2};
        vt[10] = '{3'b011, 3'b001, 8'hA0};
        vt[11] = '{3'b010, 3'b010, 8'hA1};

        reset        = 1'b1;
        uart_tx_done = 1'b0;
        for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) pkt_mem[i][j] = 8'h00;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(req_ack), 0);
        chk("rst_start", 32'(uart_start_tx), 0);
        chk("rst_din", 32'(uart_tx_din), 0);
        chk("rst_abort", 32'(abort_flag), 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // arbitration table
        dly_min = 2;
        dly_max = 2;
        for (int v = 0; v < 12; v++) begin
            run_single(vt[v].req, g, w);
            chk($sformatf("vec%0d_grant", v), 32'(g), 32'(vt[v].exp_grant));
            chk($sformatf("vec%0d_din", v), 32'(last_din), 32'(vt[v].exp_din));
        end

        // two-byte packet from requester 0, done 10 cycles after start
        dly_min = 10;
        dly_max = 10;
        s0 = n_start;
        a0 = n_ack;
        t_grant = -1; t_s1 = -1; t_s2 = -1; t_a1 = -1; d1 = 8'h00; d2 = 8'h00;
        pkt_mem[0][0] = 8'h41;
        pkt_mem[0][1] = 8'h42;
        pkt_len[0]    = 2;
        pkt_pos[0]    = 0;
        active[0]     = 1'b1;
        apply();
        for (int k = 0; k < 100 && active[0]; k++) begin
            step();
            if (grant != '0 && t_grant < 0) t_grant = cyc;
            if (uart_start_tx) begin
                if (t_s1 < 0) begin t_s1 = cyc; d1 = uart_tx_din; end
                else begin t_s2 = cyc; d2 = uart_tx_din; end
            end
            if (req_ack[0] && t_a1 < 0) t_a1 = cyc;
        end
        chk("a_starts", 32'(n_start - s0), 2);
        chk("a_acks", 32'(n_ack - a0), 2);
        chk("a_din1", 32'(d1), 32'h41);
        chk("a_din2", 32'(d2), 32'h42);
        chk("a_grant_to_start", 32'(t_s1 - t_grant), 1);
        chk("a_start_to_ack", 32'(t_a1 - t_s1), 11);
        chk("a_ack_to_start", 32'(t_s2 - t_a1), 1);
        chk("a_grant_released", 32'(grant), 0);
        // requester 0 now lowest priority: tie 011 must go to requester 1
        dly_min = 2;
        dly_max = 2;
        run_single(3'b011, g, w);
        chk("a_rr_after", 32'(g), 32'(3'b010));

        // requester 2 arrives while requester 1 is mid-packet
        new_pkt(1, 4, 8'h10);
        apply();
        for (int k = 0; k < 100 && pkt_pos[1] < 2; k++) step();
        chk("b_reached_byte2", 32'(pkt_pos[1]), 2);
        new_pkt(2, 1, 8'h77);
        apply();
        bad = 0;
        for (int k = 0; k < 100 && active[1]; k++) begin
            step();
            if (active[1] && grant !== 3'b010) bad++;
        end
        chk("b_grant_held", 32'(bad), 0);
        step();
        chk("b_next_grant", 32'(grant), 32'(3'b100));
        wait_idle(200);

        // randomized traffic
        dly_min    = 1;
        dly_max    = 6;
        pkts_begun = 0;
        pkts_done  = 0;
        rnd_mode   = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        wait_idle(2000);
        chk("rnd_pkts_done", 32'(pkts_done), 32'(pkts_begun));
        chk("start_ack_balance", 32'(n_start), 32'(n_ack));

        // requester 0 withdraws after the first ack of a 3-byte packet
        chk_en  = 1'b0;
        dly_min = 4;
        dly_max = 4;
        chk("c_abort_before", 32'(abort_flag), 0);
        new_pkt(0, 3, 8'h30);
        apply();
        for (int k = 0; k < 50 && pkt_pos[0] < 1; k++) step();
        active[0] = 1'b0;
        apply();
        s0 = n_start;
        repeat (6) step();
        chk("c_abort_flag", 32'(abort_flag), 1);
        chk("c_grant", 32'(grant), 0);
        chk("c_no_more_starts", 32'(n_start - s0), 0);

        // reset while waiting on the UART
        uart_hang = 1'b1;
        new_pkt(0, 1, 8'h55);
        apply();
        for (int k = 0; k < 10 && !uart_start_tx; k++) step();
        repeat (2) step();
        chk("d_pre_grant", 32'(grant), 32'(3'b001));
        #2 reset = 1'b1;
        #1;
        chk("d_rst_grant", 32'(grant), 0);
        chk("d_rst_ack", 32'(req_ack), 0);
        chk("d_rst_start", 32'(uart_start_tx), 0);
        chk("d_rst_din", 32'(uart_tx_din), 0);
        chk("d_rst_abort", 32'(abort_flag), 0);
        @(posedge clk);
        #1;
        clear_model();
        reset  = 1'b0;
        chk_en = 1'b1;
        run_single(3'b010, g, w);
        chk("d_grant_latency", 32'(w), 1);
        chk("d_grant_010", 32'(g), 32'(3'b010));
        do_reset();
        run_single(3'b111, g, w);
        chk("d_tie_after_reset", 32'(g), 32'(3'b001));

        // UART never answers
        chk_en    = 1'b0;
        uart_hang = 1'b1;
        a0 = n_ack;
        s0 = n_start;
        new_pkt(0, 1, 8'h99);
        apply();
        for (int k = 0; k < 10 && !uart_start_tx; k++) step();
        repeat (60) step();
`ifdef UART_ARB_TIMEOUT_EN
        chk("e_abort", 32'(abort_flag), 1);
        chk("e_grant", 32'(grant), 0);
`else
        chk("e_abort", 32'(abort_flag), 0);
        chk("e_grant", 32'(grant), 32'(3'b001));
`endif
        chk("e_no_ack", 32'(n_ack - a0), 0);
        chk("e_one_start", 32'(n_start - s0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
